// File: rtl/keypad_scan_encoder.sv
// Matrix keypad scanner/encoder: one-hot column drive, debounced snapshots, binary key codes.
// Latency: a press stable for a whole scan is reported DEBOUNCE+1 scans later (scan = COLS*SCAN_DIV+1 cycles).
// Backpressure: key_valid_o holds code until key_ready_o; events arriving while stalled are dropped with overflow_o.
//
// Ports:
//   clk_i, rst_i    clock and synchronous active-high reset
//   col_drv_o       one-hot column drive
//   row_in_i        row sense lines (already synchronised)
//   key_code_o      key index row*COLS+col
//   key_valid_o     event valid (held until accepted)
//   key_ready_i     consumer ready
//   key_release_o   event is a release (only with KEYPAD_RELEASE_EVT_EN, else 0)
//   multi_key_o     stable map has two or more keys down
//   overflow_o      one-cycle pulse: event dropped while stalled
// Optional feature macro: KEYPAD_RELEASE_EVT_EN (release events).
module keypad_scan_encoder #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  localparam int N      = ROWS * COLS,
  localparam int CODE_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [COLS-1:0]   col_drv_o,
  input  logic [ROWS-1:0]   row_in_i,
  output logic [CODE_W-1:0] key_code_o,
  output logic              key_valid_o,
  input  logic              key_ready_i,
  output logic              key_release_o,
  output logic              multi_key_o,
  output logic              overflow_o
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int COL_W  = $clog2(COLS);
  localparam int DEB_W  = $clog2(DEBOUNCE + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE);

  typedef enum logic {S_SCAN, S_EVAL} state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [COLS-1:0]     col_drv_q, col_drv_d;
  logic [N-1:0]        snap_q, snap_d, last_q, last_d, stable_q, stable_d;
  logic [DEB_W-1:0]    deb_q, deb_d;
  logic [CODE_W-1:0]   code_q, code_d, evt_code;
  logic                valid_q, valid_d, multi_q, multi_d, ovf_q, ovf_d, evt;
  int                  pc_new, pc_old;
`ifdef KEYPAD_RELEASE_EVT_EN
  logic                rel_q, rel_d, evt_rel;
`endif

  function automatic int popcnt(input logic [N-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < N; i++) n += int'(v[i]);
    return n;
  endfunction

  // Index of the lowest set bit; callers only use it when exactly one bit is set.
  function automatic logic [CODE_W-1:0] bit_idx(input logic [N-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) idx = CODE_W'(i);
    return idx;
  endfunction

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    col_d     = col_q;
    col_drv_d = col_drv_q;
    snap_d    = snap_q;
    last_d    = last_q;
    stable_d  = stable_q;
    deb_d     = deb_q;
    multi_d   = multi_q;
    evt       = 1'b0;
    evt_code  = '0;
    pc_new    = popcnt(snap_q);
    pc_old    = popcnt(stable_q);
`ifdef KEYPAD_RELEASE_EVT_EN
    evt_rel   = 1'b0;
`endif

    case (state_q)
      S_SCAN: begin
        if (slot_q == LAST_SLOT) begin
          slot_d = '0;
          for (int r = 0; r < ROWS; r++) snap_d[r*COLS + int'(col_q)] = row_in_i[r];
          if (col_q != LAST_COL) begin
            col_d     = col_q + 1'b1;
            col_drv_d = {col_drv_q[COLS-2:0], col_drv_q[COLS-1]};
          end else begin
            state_d = S_EVAL;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      S_EVAL: begin
        state_d   = S_SCAN;
        col_d     = '0;
        col_drv_d = COLS'(1);
        last_d    = snap_q;
        if (snap_q == last_q) begin
          if (deb_q != DEB_MAX) deb_d = deb_q + 1'b1;
        end else begin
          deb_d = '0;
        end
        // The threshold is checked on the updated count, so the scan that
        // completes the debounce run commits immediately.
        if (deb_d == DEB_MAX && snap_q != stable_q) begin
          stable_d = snap_q;
          multi_d  = (pc_new >= 2);
          if (pc_new == 1 && pc_old == 0) begin
            evt      = 1'b1;
            evt_code = bit_idx(snap_q);
          end
`ifdef KEYPAD_RELEASE_EVT_EN
          if (pc_new == 0 && pc_old == 1) begin
            evt      = 1'b1;
            evt_code = bit_idx(stable_q);
            evt_rel  = 1'b1;
          end
`endif
        end
      end
      default: state_d = S_SCAN;
    endcase

    // Output handshake: a new event wins over a same-cycle accept.
    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = 1'b0;
`ifdef KEYPAD_RELEASE_EVT_EN
    rel_d   = rel_q;
`endif
    if (evt) begin
      if (valid_q && !key_ready_i) begin
        ovf_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        code_d  = evt_code;
`ifdef KEYPAD_RELEASE_EVT_EN
        rel_d   = evt_rel;
`endif
      end
    end else if (valid_q && key_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_SCAN;
      slot_q    <= '0;
      col_q     <= '0;
      col_drv_q <= COLS'(1);
      snap_q    <= '0;
      last_q    <= '0;
      stable_q  <= '0;
      deb_q     <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      multi_q   <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef KEYPAD_RELEASE_EVT_EN
      rel_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      col_q     <= col_d;
      col_drv_q <= col_drv_d;
      snap_q    <= snap_d;
      last_q    <= last_d;
      stable_q  <= stable_d;
      deb_q     <= deb_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      multi_q   <= multi_d;
      ovf_q     <= ovf_d;
`ifdef KEYPAD_RELEASE_EVT_EN
      rel_q     <= rel_d;
`endif
    end
  end

  assign col_drv_o   = col_drv_q;
  assign key_code_o  = code_q;
  assign key_valid_o = valid_q;
  assign multi_key_o = multi_q;
  assign overflow_o  = ovf_q;
`ifdef KEYPAD_RELEASE_EVT_EN
  assign key_release_o = rel_q;
`else
  assign key_release_o = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder with ROWS=COLS=4, SCAN_DIV=2, DEBOUNCE=2 (9-cycle scan).
// A behavioural keypad model turns a pressed-key map into row sense lines from col_drv.
// Expectations follow KEYPAD_RELEASE_EVT_EN when the bench is built with it.
module tb_keypad_scan_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_drv;
  logic [3:0]  row_in;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_release;
  logic        multi_key;
  logic        overflow;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;

  // Per-window monitor results
  int   vrise, first_rise, ocnt;
  logic [3:0] lcode;
  logic lrel, prev_valid;

`ifdef KEYPAD_RELEASE_EVT_EN
  localparam int REL_EN = 1;
`else
  localparam int REL_EN = 0;
`endif

  keypad_scan_encoder #(.ROWS(4), .COLS(4), .SCAN_DIV(2), .DEBOUNCE(2)) dut (
    .clk_i(clk), .rst_i(rst), .col_drv_o(col_drv), .row_in_i(row_in),
    .key_code_o(key_code), .key_valid_o(key_valid), .key_ready_i(key_ready),
    .key_release_o(key_release), .multi_key_o(multi_key), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && col_drv[c]) row_in[r] = 1'b1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles, counting rising edges of key_valid and overflow pulses.
  task automatic run(input int n);
    vrise = 0; first_rise = 0; ocnt = 0; lcode = '0; lrel = 1'b0;
    prev_valid = key_valid;
    for (int i = 1; i <= n; i++) begin
      step();
      if (key_valid && !prev_valid) begin
        vrise++;
        lcode = key_code;
        lrel  = key_release;
        if (first_rise == 0) first_rise = i;
      end
      if (overflow) ocnt++;
      prev_valid = key_valid;
    end
  endtask

  logic [3:0] seq_exp [9];

  initial begin
    seq_exp = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                4'b1000, 4'b1000, 4'b1000, 4'b0001};
    keys = '0; key_ready = 1'b1; rst = 1'b1;

    // 1. reset and column sequencing
    step(); step(); step();
    check("rst_col_drv", int'(col_drv), 1);
    check("rst_valid", int'(key_valid), 0);
    check("rst_code", int'(key_code), 0);
    check("rst_multi", int'(multi_key), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_rel", int'(key_release), 0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("col_seq%0d", i), int'(col_drv), int'(seq_exp[i]));
    end

    // 2. key 6 pressed at the start of a scan: reported after exactly 3 scans
    keys = 16'h0040;
    run(36);
    check("k6_pulses", vrise, 1);
    check("k6_latency", first_rise, 27);
    check("k6_code", int'(lcode), 6);
    check("k6_rel", int'(lrel), 0);
    check("k6_multi", int'(multi_key), 0);
    run(27);
    check("k6_no_repeat", vrise, 0);
    keys = '0;
    run(36);
    check("k6_release_evts", vrise, REL_EN);
    if (REL_EN != 0) check("k6_release_code", int'(lcode), 6);

    // 3. key 9 glitch for one scan
    keys = 16'h0200;
    run(9);
    keys = '0;
    run(36);
    check("glitch_pulses", vrise, 0);
    check("glitch_multi", int'(multi_key), 0);

    // 4. keys 0 and 15 together
    keys = 16'h8001;
    run(36);
    check("multi_pulses", vrise, 0);
    check("multi_set", int'(multi_key), 1);
    keys = '0;
    run(36);
    check("multi_rel_pulses", vrise, 0);
    check("multi_clear", int'(multi_key), 0);

    // 5. stalled consumer: press 3, release, press 12
    key_ready = 1'b0;
    keys = 16'h0008;
    run(36);
    check("stall_valid", int'(key_valid), 1);
    check("stall_code", int'(key_code), 3);
    keys = '0;
    run(36);
    check("stall_rel_ovf", ocnt, REL_EN);
    keys = 16'h1000;
    run(36);
    check("stall_ovf", ocnt, 1);
    check("stall_code_held", int'(key_code), 3);
    check("stall_valid_held", int'(key_valid), 1);
    key_ready = 1'b1;
    #1;
    check("accept_code", int'(key_code), 3);
    step();
    check("accept_drop", int'(key_valid), 0);
    keys = '0;
    run(36);
    check("k12_release_evts", vrise, REL_EN);

    // 6. reset mid-handshake, then press/release key 5
    key_ready = 1'b0;
    keys = 16'h0020;
    run(36);
    check("k5_valid", int'(key_valid), 1);
    check("k5_code", int'(key_code), 5);
    rst = 1'b1;
    step();
    check("midrst_valid", int'(key_valid), 0);
    check("midrst_col", int'(col_drv), 1);
    check("midrst_code", int'(key_code), 0);
    rst = 1'b0;
    key_ready = 1'b1;
    run(36);
    check("k5_again", vrise, 1);
    check("k5_again_code", int'(lcode), 5);
    keys = '0;
    run(36);
    check("k5_release_evts", vrise, REL_EN);
    if (REL_EN != 0) begin
      check("k5_release_code", int'(lcode), 5);
      check("k5_release_flag", int'(lrel), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
